param_data_stack: RTL and testbench
===================================

Name: param_data_stack

Overview:
- Parametrised data stack for the next-generation stack processor.
- Holds the operand stack with top and second entries in registers and deeper entries in an array; executes one stack op per cycle.
- Presents TOS/SOS combinationally to the ALU.
- Generalises the fixed 16-bit stack: WIDTH and DEPTH are parameters; adds occupancy, full/empty, and sticky overflow/underflow error reporting.

Parameters:
- WIDTH, 16, data word width in bits
- DEPTH, 32, total entries including TOS and SOS; must be >= 4
- CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
- CLK  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- op_valid  input  1  execute op this cycle when high
- op  input  3  0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 OVER, 5 SWAP, 6 BINOP, 7 REPLACE
- push_data  input  WIDTH  value for PUSH
- alu_result  input  WIDTH  value for BINOP/REPLACE
- clear_err  input  1  clears sticky error flags
- top_of_stack  output  WIDTH  entry 0; reads 0 when empty
- second_of_stack  output  WIDTH  entry 1; reads 0 when count < 2
- count  output  CNT_W  number of valid entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow_err  output  1  sticky; illegal growth attempted
- underflow_err  output  1  sticky; illegal shrink/read attempted

Behaviour:
- Reset, synchronous: count = 0; all entries = 0; both error flags = 0. Therefore empty = 1, full = 0, TOS/SOS = 0.
- Outputs are registered state. An op with op_valid high is visible on TOS/SOS/count the cycle after the edge.
- The ALU consumes the current TOS/SOS combinationally and returns alu_result in the same cycle.
- Op semantics (E0 = TOS, E1 = SOS, Ek deeper):
  - PUSH: shift down; E0 = push_data; count + 1
  - DROP: shift up; count - 1
  - DUP: shift down; E0 = old E0; count + 1
  - OVER: shift down; E0 = old E1; count + 1
  - SWAP: exchange E0 and E1; count unchanged
  - BINOP: E0 = alu_result; E1.. shift up from E2..; count - 1
  - REPLACE: E0 = alu_result; count unchanged
- Legality requirements:
  - PUSH: count < DEPTH
  - DUP: 1 <= count < DEPTH
  - OVER: 2 <= count < DEPTH
  - DROP, REPLACE: count >= 1
  - SWAP, BINOP: count >= 2
- Illegal op: stack state unchanged. The growth-limit violation sets overflow_err; the operand shortage sets underflow_err. For DUP/OVER, operand shortage takes priority over full.
- Vacated slots are written 0 on shrink, so entries at index >= count always read 0.
- op_valid low, or NOP: no state change.
- clear_err and a new error on the same cycle: the error wins and the flag stays 1.
- reset high during any op: reset wins.

Optional Feature:
- Macro: DSTACK_PEEK_EN.
- Defined: adds ports peek_idx (input, CNT_W) and peek_data (output, WIDTH).
  - peek_data is registered: one cycle after peek_idx is presented it shows the entry at that index, sampled before the same-edge op.
  - Index >= count returns 0. Reset clears peek_data to 0.
- Undefined: no peek ports and no extra read logic.

Decomposition:
- Shared package dstack_pkg:
  - op encoding constants OP_NOP..OP_REPLACE
  - localparam for the default WIDTH
- One natural sub-module: dstack_legal, a combinational legality check taking op and count and producing ok, ovf, and unf.
- Shift array and count stay in the top module.

Test Plan:
- Reset, then PUSH 1, PUSH 2, PUSH 3, BINOP with alu_result 5 -> TOS 5, SOS 1, count 2, no errors.
- PUSH 1, PUSH 2, OVER, DUP -> TOS 1, SOS 1, count 4.
- PUSH 1, PUSH 2, PUSH 3, SWAP, DROP -> TOS 3, SOS 1, count 2; a further DROP gives TOS 1, SOS 0.
- DEPTH = 4: five PUSHes of 10..14 -> full = 1, TOS 13, overflow_err = 1, count 4; clear_err -> flag 0.
- From reset, SWAP -> underflow_err = 1, count 0, TOS 0.
- Then PUSH 7, DUP, reset mid-sequence -> all outputs 0, empty = 1.
- With DSTACK_PEEK_EN: PUSH 4, 5, 6, peek_idx 2 -> peek_data 4 next cycle; peek_idx 3 -> 0.

Source files
------------

// File: rtl/dstack_pkg.sv
// Shared definitions for the parametrised data stack: op encodings and default word width.
package dstack_pkg;

    localparam int unsigned DSTACK_WIDTH_DEFAULT = 16;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_DROP    = 3'd2;
    localparam logic [2:0] OP_DUP     = 3'd3;
    localparam logic [2:0] OP_OVER    = 3'd4;
    localparam logic [2:0] OP_SWAP    = 3'd5;
    localparam logic [2:0] OP_BINOP   = 3'd6;
    localparam logic [2:0] OP_REPLACE = 3'd7;

endpackage

// File: rtl/dstack_legal.sv
// Combinational legality check for a stack op against the current occupancy.
module dstack_legal
    import dstack_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    output logic             ok,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

    logic [CNT_W-1:0] need;
    logic             grow;

    always_comb begin
        need = '0;
        grow = 1'b0;
        unique case (op)
            OP_PUSH:               grow = 1'b1;
            OP_DROP, OP_REPLACE:   need = CNT_W'(1);
            OP_DUP: begin
                need = CNT_W'(1);
                grow = 1'b1;
            end
            OP_OVER: begin
                need = CNT_W'(2);
                grow = 1'b1;
            end
            OP_SWAP, OP_BINOP:     need = CNT_W'(2);
            default:               ;
        endcase
    end

    // Operand shortage is reported ahead of a full stack.
    always_comb begin
        unf = (count < need);
        ovf = ~unf & grow & (count >= DepthC);
        ok  = ~unf & ~ovf;
    end

endmodule

// File: rtl/param_data_stack.sv
// Parametrised operand stack: TOS/SOS in slots 0/1, one op per cycle, sticky error flags.
// Optional registered peek port enabled by defining DSTACK_PEEK_EN.
module param_data_stack
    import dstack_pkg::*;
#(
    parameter int unsigned WIDTH = DSTACK_WIDTH_DEFAULT,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             clear_err,
`ifdef DSTACK_PEEK_EN
    input  logic [CNT_W-1:0] peek_idx,
    output logic [WIDTH-1:0] peek_data,
`endif
    output logic [WIDTH-1:0] top_of_stack,
    output logic [WIDTH-1:0] second_of_stack,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] OneC   = CNT_W'(1);

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [WIDTH-1:0] entries_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic legal_ok, legal_ovf, legal_unf;

    dstack_legal #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_legal (
        .op    (op),
        .count (count_q),
        .ok    (legal_ok),
        .ovf   (legal_ovf),
        .unf   (legal_unf)
    );

    // Shrinking ops refill the bottom slot with 0 so entries at index >= count stay 0.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (op_valid && legal_ok) begin
            unique case (op)
                OP_PUSH, OP_DUP, OP_OVER: begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        entries_d[i] = entries_q[i-1];
                    end
                    if (op == OP_PUSH) begin
                        entries_d[0] = push_data;
                    end else if (op == OP_DUP) begin
                        entries_d[0] = entries_q[0];
                    end else begin
                        entries_d[0] = entries_q[1];
                    end
                    count_d = count_q + OneC;
                end
                OP_DROP: begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        entries_d[i] = entries_q[i+1];
                    end
                    entries_d[DEPTH-1] = '0;
                    count_d = count_q - OneC;
                end
                OP_SWAP: begin
                    entries_d[0] = entries_q[1];
                    entries_d[1] = entries_q[0];
                end
                OP_BINOP: begin
                    entries_d[0] = alu_result;
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        entries_d[i] = entries_q[i+1];
                    end
                    entries_d[DEPTH-1] = '0;
                    count_d = count_q - OneC;
                end
                OP_REPLACE: entries_d[0] = alu_result;
                default:    ;
            endcase
        end
    end

    // A fresh error beats clear_err on the same cycle.
    always_comb begin
        ovf_d = (ovf_q & ~clear_err) | (op_valid & legal_ovf);
        unf_d = (unf_q & ~clear_err) | (op_valid & legal_unf);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign top_of_stack    = entries_q[0];
    assign second_of_stack = entries_q[1];
    assign count           = count_q;
    assign empty           = (count_q == '0);
    assign full            = (count_q == DepthC);
    assign overflow_err    = ovf_q;
    assign underflow_err   = unf_q;

`ifdef DSTACK_PEEK_EN
    logic [WIDTH-1:0] peek_sel;
    logic [WIDTH-1:0] peek_q;

    // Unused slots already hold 0, so no separate compare against count is needed.
    always_comb begin
        peek_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (peek_idx == CNT_W'(i)) begin
                peek_sel = entries_q[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            peek_q <= '0;
        end else begin
            peek_q <= peek_sel;
        end
    end

    assign peek_data = peek_q;
`endif

endmodule

// File: tb/tb_param_data_stack.sv
// Self-checking bench for param_data_stack (DEPTH = 4): queue model plus literal pins.
module tb_param_data_stack;
    import dstack_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op = OP_NOP;
    logic [W-1:0]  push_data = '0;
    logic [W-1:0]  alu_result = '0;
    logic          clear_err = 1'b0;
    logic [CW-1:0] peek_idx = '0;
    logic [W-1:0]  peek_data;
    logic [W-1:0]  top_of_stack, second_of_stack;
    logic [CW-1:0] count;
    logic          empty, full, overflow_err, underflow_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Model: m[0] is the top of stack.
    logic [W-1:0] m[$];
    bit           m_ovf, m_unf;
    logic [W-1:0] m_peek;

    always #5 clk = ~clk;

    param_data_stack #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .CLK             (clk),
        .reset           (rst),
        .op_valid        (op_valid),
        .op              (op),
        .push_data       (push_data),
        .alu_result      (alu_result),
        .clear_err       (clear_err),
`ifdef DSTACK_PEEK_EN
        .peek_idx        (peek_idx),
        .peek_data       (peek_data),
`endif
        .top_of_stack    (top_of_stack),
        .second_of_stack (second_of_stack),
        .count           (count),
        .empty           (empty),
        .full            (full),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err)
    );

`ifndef DSTACK_PEEK_EN
    assign peek_data = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ent(input int i);
        return (m.size() > i) ? m[i] : '0;
    endfunction

    task automatic model_step(input logic v, input logic [2:0] o, input logic [W-1:0] pd,
                              input logic [W-1:0] alu, input logic clr, input logic r,
                              input logic [CW-1:0] pi);
        bit e_ovf, e_unf;
        int n;
        logic [W-1:0] t;
        if (r) begin
            m.delete();
            m_ovf  = 0;
            m_unf  = 0;
            m_peek = '0;
            return;
        end
        m_peek = ent(int'(pi));
        n = m.size();
        e_ovf = 0;
        e_unf = 0;
        if (v) begin
            case (o)
                OP_PUSH:    if (n >= D) e_ovf = 1; else m.push_front(pd);
                OP_DROP:    if (n < 1) e_unf = 1; else void'(m.pop_front());
                OP_DUP:     if (n < 1) e_unf = 1; else if (n >= D) e_ovf = 1;
                            else m.push_front(m[0]);
                OP_OVER:    if (n < 2) e_unf = 1; else if (n >= D) e_ovf = 1;
                            else m.push_front(m[1]);
                OP_SWAP:    if (n < 2) e_unf = 1; else begin
                                t = m[0]; m[0] = m[1]; m[1] = t;
                            end
                OP_BINOP:   if (n < 2) e_unf = 1; else begin
                                void'(m.pop_front()); m[0] = alu;
                            end
                OP_REPLACE: if (n < 1) e_unf = 1; else m[0] = alu;
                default:    ;
            endcase
        end
        m_ovf = e_ovf | (m_ovf & ~clr);
        m_unf = e_unf | (m_unf & ~clr);
    endtask

    task automatic step(input logic v, input logic [2:0] o, input logic [W-1:0] pd,
                        input logic [W-1:0] alu, input logic clr, input logic r);
        rst = r; op_valid = v; op = o; push_data = pd; alu_result = alu; clear_err = clr;
        @(posedge clk);
        model_step(v, o, pd, alu, clr, r, peek_idx);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, OP_NOP, '0, '0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] x);
        step(1'b1, OP_PUSH, x, '0, 1'b0, 1'b0);
    endtask

    task automatic doop(input logic [2:0] o, input logic [W-1:0] alu);
        step(1'b1, o, '0, alu, 1'b0, 1'b0);
    endtask

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("tos",   32'(top_of_stack),    32'(ent(0)));
            chk("sos",   32'(second_of_stack), 32'(ent(1)));
            chk("count", 32'(count),           32'(m.size()));
            chk("empty", 32'(empty),           32'(m.size() == 0));
            chk("full",  32'(full),            32'(m.size() == D));
            chk("ovf",   32'(overflow_err),    32'(m_ovf));
            chk("unf",   32'(underflow_err),   32'(m_unf));
`ifdef DSTACK_PEEK_EN
            chk("peek",  32'(peek_data),       32'(m_peek));
`endif
        end
    end

    initial begin
        do_reset();
        chk_on = 1'b1;
        do_reset();
        chk("pin_rst_tos", 32'(top_of_stack), 0);
        chk("pin_rst_empty", 32'(empty), 1);

        // PUSH 1,2,3 then BINOP -> [5,1]
        push(1); push(2); push(3); doop(OP_BINOP, 16'd5);
        chk("pin_binop_tos", 32'(top_of_stack), 5);
        chk("pin_binop_sos", 32'(second_of_stack), 1);
        chk("pin_binop_cnt", 32'(count), 2);
        chk("pin_binop_err", 32'({overflow_err, underflow_err}), 0);

        // PUSH 1,2, OVER, DUP -> [1,1,2,1]
        do_reset();
        push(1); push(2); doop(OP_OVER, '0); doop(OP_DUP, '0);
        chk("pin_overdup_tos", 32'(top_of_stack), 1);
        chk("pin_overdup_sos", 32'(second_of_stack), 1);
        chk("pin_overdup_cnt", 32'(count), 4);

        // PUSH 1,2,3, SWAP, DROP -> [3,1]; DROP -> [1]
        do_reset();
        push(1); push(2); push(3); doop(OP_SWAP, '0); doop(OP_DROP, '0);
        chk("pin_swapdrop_tos", 32'(top_of_stack), 3);
        chk("pin_swapdrop_sos", 32'(second_of_stack), 1);
        doop(OP_DROP, '0);
        chk("pin_drop2_tos", 32'(top_of_stack), 1);
        chk("pin_drop2_sos", 32'(second_of_stack), 0);
        doop(OP_OVER, '0);  // shortage with count 1
        doop(OP_BINOP, '0);
        doop(OP_DROP, '0);
        doop(OP_DROP, '0);  // drop on empty

        // Overflow at DEPTH 4
        do_reset();
        for (int i = 10; i <= 14; i++) push(16'(i));
        chk("pin_ovf_full", 32'(full), 1);
        chk("pin_ovf_tos", 32'(top_of_stack), 13);
        chk("pin_ovf_flag", 32'(overflow_err), 1);
        step(1'b0, OP_NOP, '0, '0, 1'b1, 1'b0);
        chk("pin_clr_flag", 32'(overflow_err), 0);
        step(1'b1, OP_PUSH, 16'd99, '0, 1'b1, 1'b0);  // error beats clear
        chk("pin_err_wins", 32'(overflow_err), 1);
        step(1'b0, OP_DROP, '0, '0, 1'b1, 1'b0);      // invalid op ignored
        doop(OP_DUP, '0);
        doop(OP_OVER, '0);
        doop(OP_REPLACE, 16'h00AB);
        doop(OP_SWAP, '0);
        doop(OP_BINOP, 16'h1234);
        doop(OP_NOP, '0);

        // Underflow from reset, then reset mid-sequence
        do_reset();
        doop(OP_SWAP, '0);
        chk("pin_unf_flag", 32'(underflow_err), 1);
        chk("pin_unf_cnt", 32'(count), 0);
        push(7); doop(OP_DUP, '0);
        step(1'b1, OP_PUSH, 16'd8, '0, 1'b0, 1'b1);
        rst = 1'b0;
        chk("pin_rst_mid_tos", 32'(top_of_stack), 0);
        chk("pin_rst_mid_empty", 32'(empty), 1);
        chk("pin_rst_mid_unf", 32'(underflow_err), 0);

`ifdef DSTACK_PEEK_EN
        push(4); push(5); push(6);
        peek_idx = 2;
        doop(OP_NOP, '0);
        chk("pin_peek2", 32'(peek_data), 4);
        peek_idx = 3;
        doop(OP_DROP, '0);
        chk("pin_peek3", 32'(peek_data), 0);
        peek_idx = 0;
        doop(OP_NOP, '0);
`endif

        doop(OP_NOP, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
